ls_rs: RTL

Load/store reservation station sitting directly upstream of the load-store buffer. It holds dispatched memory instructions until their base-register and store-data operands arrive on the two common data buses. It then computes the effective address and hands one resolved instruction per cycle to the load-store buffer, keyed by ROB tag.

---
 rtl/ls_rs.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ls_rs.sv
// Load/store reservation station: holds memory ops until base and store-data operands
// arrive on the CDBs, then issues one resolved op per cycle to the load-store buffer.
module ls_rs #(
    parameter int RS_SIZE   = 4,
    parameter int RS_WIDTH  = 2,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_valid,
    input  logic [3:0]           dec_op,
    input  logic [ROB_WIDTH-1:0] dec_tag,
    input  logic                 dec_qj_valid,
    input  logic [ROB_WIDTH-1:0] dec_qj,
    input  logic [31:0]          dec_vj,
    input  logic                 dec_qk_valid,
    input  logic [ROB_WIDTH-1:0] dec_qk,
    input  logic [31:0]          dec_vk,
    input  logic [31:0]          dec_imm,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_WIDTH-1:0] cdb_alu_tag,
    input  logic [31:0]          cdb_alu_data,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_lsb_tag,
    input  logic [31:0]          cdb_lsb_data,
    output logic                 to_decoder,
    output logic                 to_lsb,
    output logic [3:0]           to_lsb_op,
    output logic [ROB_WIDTH-1:0] to_lsb_tag,
    output logic [31:0]          to_lsb_wdata,
    output logic [31:0]          to_lsb_address
);
    localparam logic [RS_WIDTH:0] CNT_ONE  = (RS_WIDTH+1)'(1);
    localparam logic [RS_WIDTH:0] CNT_FULL = (RS_WIDTH+1)'(RS_SIZE);

    function automatic logic f_is_store(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_qj_valid;
    logic [RS_SIZE-1:0]   r_qk_valid;
    logic [3:0]           r_op  [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_tag [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qj  [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qk  [RS_SIZE];
    logic [31:0]          r_vj  [RS_SIZE];
    logic [31:0]          r_vk  [RS_SIZE];
    logic [31:0]          r_imm [RS_SIZE];

    logic                w_has_free;
    logic                w_has_iss;
    logic [RS_WIDTH-1:0] w_free_idx;
    logic [RS_WIDTH-1:0] w_iss_idx;
    logic [RS_SIZE-1:0]  w_ready;
    logic [RS_WIDTH:0]   w_cnt_next;
    logic                w_dispatch;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_has_iss  = 1'b0;
        w_iss_idx  = '0;
        w_ready    = r_busy & ~r_qj_valid & ~r_qk_valid;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_has_free = 1'b1;
                w_free_idx = RS_WIDTH'(i);
            end
            if (w_ready[i]) begin
                w_has_iss = 1'b1;
                w_iss_idx = RS_WIDTH'(i);
            end
        end
    end

    assign w_dispatch = dec_valid & w_has_free;

    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_cnt_next = w_cnt_next + (RS_WIDTH+1)'(r_busy[i]);
        end
        if (w_dispatch) w_cnt_next = w_cnt_next + CNT_ONE;
        if (w_has_iss)  w_cnt_next = w_cnt_next - CNT_ONE;
    end

    // Dispatch-time bypass: an operand broadcast in the same cycle is captured as ready.
    logic        w_dj_alu, w_dj_lsb, w_dk_alu, w_dk_lsb, w_dk_pend;
    logic        w_dqj_valid, w_dqk_valid;
    logic [31:0] w_dvj, w_dvk;

    assign w_dj_alu    = cdb_alu_valid && (cdb_alu_tag == dec_qj);
    assign w_dj_lsb    = cdb_lsb_valid && (cdb_lsb_tag == dec_qj);
    assign w_dk_alu    = cdb_alu_valid && (cdb_alu_tag == dec_qk);
    assign w_dk_lsb    = cdb_lsb_valid && (cdb_lsb_tag == dec_qk);
    assign w_dk_pend   = dec_qk_valid && f_is_store(dec_op);
    assign w_dqj_valid = dec_qj_valid && !w_dj_alu && !w_dj_lsb;
    assign w_dqk_valid = w_dk_pend && !w_dk_alu && !w_dk_lsb;
    assign w_dvj = !dec_qj_valid ? dec_vj :
                   w_dj_alu      ? cdb_alu_data :
                   w_dj_lsb      ? cdb_lsb_data : dec_vj;
    assign w_dvk = !w_dk_pend    ? dec_vk :
                   w_dk_alu      ? cdb_alu_data :
                   w_dk_lsb      ? cdb_lsb_data : dec_vk;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy         <= '0;
            r_qj_valid     <= '0;
            r_qk_valid     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_tag[i] <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_imm[i] <= '0;
            end
            to_decoder     <= 1'b1;
            to_lsb         <= 1'b0;
            to_lsb_op      <= '0;
            to_lsb_tag     <= '0;
            to_lsb_wdata   <= '0;
            to_lsb_address <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                r_busy     <= '0;
                to_lsb     <= 1'b0;
                to_decoder <= 1'b1;
            end else begin
                // ALU bus wins when both broadcasts carry the awaited tag.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_valid[i]) begin
                        if (cdb_alu_valid && (cdb_alu_tag == r_qj[i])) begin
                            r_vj[i]       <= cdb_alu_data;
                            r_qj_valid[i] <= 1'b0;
                        end else if (cdb_lsb_valid && (cdb_lsb_tag == r_qj[i])) begin
                            r_vj[i]       <= cdb_lsb_data;
                            r_qj_valid[i] <= 1'b0;
                        end
                    end
                    if (r_busy[i] && r_qk_valid[i]) begin
                        if (cdb_alu_valid && (cdb_alu_tag == r_qk[i])) begin
                            r_vk[i]       <= cdb_alu_data;
                            r_qk_valid[i] <= 1'b0;
                        end else if (cdb_lsb_valid && (cdb_lsb_tag == r_qk[i])) begin
                            r_vk[i]       <= cdb_lsb_data;
                            r_qk_valid[i] <= 1'b0;
                        end
                    end
                end

                if (w_has_iss) begin
                    r_busy[w_iss_idx] <= 1'b0;
                    to_lsb            <= 1'b1;
                    to_lsb_op         <= r_op[w_iss_idx];
                    to_lsb_tag        <= r_tag[w_iss_idx];
                    to_lsb_address    <= r_vj[w_iss_idx] + r_imm[w_iss_idx];
                    to_lsb_wdata      <= f_is_store(r_op[w_iss_idx]) ? r_vk[w_iss_idx] : 32'd0;
                end else begin
                    to_lsb <= 1'b0;
                end

                // The free slot is non-busy and the issuing slot is busy, so they never coincide.
                if (w_dispatch) begin
                    r_busy[w_free_idx]     <= 1'b1;
                    r_op[w_free_idx]       <= dec_op;
                    r_tag[w_free_idx]      <= dec_tag;
                    r_qj_valid[w_free_idx] <= w_dqj_valid;
                    r_qj[w_free_idx]       <= dec_qj;
                    r_vj[w_free_idx]       <= w_dvj;
                    r_qk_valid[w_free_idx] <= w_dqk_valid;
                    r_qk[w_free_idx]       <= dec_qk;
                    r_vk[w_free_idx]       <= w_dvk;
                    r_imm[w_free_idx]      <= dec_imm;
                end

                to_decoder <= (w_cnt_next < CNT_FULL);
            end
        end
    end
endmodule
